// File: rtl/booth_multiplier32.sv
// -----------------------------------------------------------------------------
// booth_multiplier32
//
// Sequential 32x32 signed two's-complement multiplier. It uses radix-4
// (modified) Booth recoding and retires one recoded digit per clock, so a
// product takes 16 iterations.
//
// Handshake (valid/ready):
//   ready=1 means the unit is idle, R holds the last complete product, and a
//   start is accepted. A start is accepted on any rising clk edge where
//   ready=1 and valid=1; A and B are latched on that edge. While ready=0,
//   valid is ignored (no queuing, no restart). R is written only on the edge
//   that performs the final Booth step, and ready rises on that same edge.
//
// Ports:
//   clk        in   1   rising-edge clock
//   async_rst  in   1   asynchronous active-high reset (R=0, ready=1)
//   valid      in   1   start request
//   A          in  32   signed multiplicand
//   B          in  32   signed multiplier
//   R          out 64   signed product A*B, registered
//   ready      out  1   1 = idle / result valid, 0 = busy
// -----------------------------------------------------------------------------
module booth_multiplier32 (
  input  logic        clk,
  input  logic        async_rst,
  input  logic        valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] R,
  output logic        ready
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_m;      // latched multiplicand
  logic [33:0] r_acc;    // signed accumulator, upper half of the shift pair
  logic [32:0] r_q;      // {multiplier, bit -1}; lower half of the shift pair
  logic [3:0]  r_cnt;    // Booth step index 0..15

  logic        w_start;
  logic        w_step;
  logic        w_last;

  logic [33:0] w_m1;     // +M sign-extended to 34 bits
  logic [33:0] w_m2;     // +2M in 34 bits
  logic [33:0] w_pp;     // selected partial product
  logic [33:0] w_sum;
  logic [33:0] w_acc_next;
  logic [32:0] w_q_next;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    w_start      = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (valid) begin
          w_start      = 1'b1;
          w_state_next = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == 4'd15) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Booth step: select partial product from the low triplet of r_q, add it to
  // the accumulator, then shift the 67-bit {acc, q} pair right by 2
  // arithmetically. Products fit easily: |acc| stays below 2^32 after each
  // shift, so a 34-bit sum never overflows.
  // ---------------------------------------------------------------------------
  assign w_m1 = {{2{r_m[31]}}, r_m};
  assign w_m2 = {r_m[31], r_m, 1'b0};

  always_comb begin
    w_pp = 34'd0;
    case (r_q[2:0])
      3'b001, 3'b010: w_pp = w_m1;
      3'b011:         w_pp = w_m2;
      3'b100:         w_pp = ~w_m2 + 34'd1;
      3'b101, 3'b110: w_pp = ~w_m1 + 34'd1;
      default:        w_pp = 34'd0;
    endcase
  end

  assign w_sum      = r_acc + w_pp;
  assign w_acc_next = {{2{w_sum[33]}}, w_sum[33:2]};
  assign w_q_next   = {w_sum[1:0], r_q[32:2]};

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_m   <= 32'd0;
      r_acc <= 34'd0;
      r_q   <= 33'd0;
      r_cnt <= 4'd0;
    end else if (w_start) begin
      r_m   <= A;
      r_acc <= 34'd0;
      r_q   <= {B, 1'b0};
      r_cnt <= 4'd0;
    end else if (w_step) begin
      r_acc <= w_acc_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // After 16 shifts of 2, {acc, q[32:1]} is the 66-bit product; the low 64
  // bits are the exact signed result.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      R <= 64'd0;
    end else if (w_last) begin
      R <= {w_acc_next[31:0], w_q_next[32:1]};
    end
  end

endmodule

// File: tb/tb_booth_multiplier32.sv
// -----------------------------------------------------------------------------
// tb_booth_multiplier32
//
// Directed testbench for booth_multiplier32. Each scenario lives in its own
// task with inline comparisons; a single initial block runs them in order and
// prints the summary line.
// -----------------------------------------------------------------------------
module tb_booth_multiplier32;

  logic        clk;
  logic        async_rst;
  logic        valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] R;
  logic        ready;

  int checks;
  int errors;

  booth_multiplier32 dut (
    .clk       (clk),
    .async_rst (async_rst),
    .valid     (valid),
    .A         (A),
    .B         (B),
    .R         (R),
    .ready     (ready)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Present operands with valid for exactly one rising edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A     = a;
    B     = b;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  // Count rising edges until ready rises, bounded at 40.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (ready !== 1'b1 && lat < 40);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // Power-on reset first.
    async_rst = 1'b1;
    valid     = 1'b0;
    A         = 32'd0;
    B         = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_rst = 1'b0;
    #1;
    checks++;
    if (R !== 64'd0 || ready !== 1'b1) begin
      $display("FAIL reset_por: R=%h ready=%b, want R=0 ready=1", R, ready);
      errors++;
    end
  endtask

  task automatic test_reset_async();
    int lat;
    // Load a nonzero result, then reset between edges.
    start_op(32'd9, 32'd9);
    wait_done(lat);
    checks++;
    if (R !== 64'd81) begin
      $display("FAIL pre_async_rst: R=%h want %h", R, 64'd81);
      errors++;
    end
    @(negedge clk);
    #1;
    async_rst = 1'b1;
    #1;
    checks++;
    if (R !== 64'd0 || ready !== 1'b1) begin
      $display("FAIL async_rst_immediate: R=%h ready=%b, want R=0 ready=1", R, ready);
      errors++;
    end
    @(negedge clk);
    async_rst = 1'b0;
  endtask

  task automatic test_positive();
    int lat;
    start_op(32'd3, 32'd5);
    checks++;
    if (ready !== 1'b0) begin
      $display("FAIL pos_busy: ready=%b want 0", ready);
      errors++;
    end
    wait_done(lat);
    checks++;
    if (lat !== 16) begin
      $display("FAIL pos_latency: got %0d cycles want 16", lat);
      errors++;
    end
    checks++;
    if (R !== 64'h0000_0000_0000_000F) begin
      $display("FAIL pos_result: R=%h want %h", R, 64'h0000_0000_0000_000F);
      errors++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (R !== 64'h0000_0000_0000_000F || ready !== 1'b1) begin
      $display("FAIL pos_stable: R=%h ready=%b want R=f ready=1", R, ready);
      errors++;
    end
  endtask

  task automatic test_signs_extremes();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [63:0] ve [5];
    int lat;
    va[0] = 32'hFFFF_FFF9; vb[0] = 32'd6;          ve[0] = 64'hFFFF_FFFF_FFFF_FFD6;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'h8000_0000;  ve[1] = 64'hC000_0000_8000_0000;
    va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000;  ve[2] = 64'h4000_0000_0000_0000;
    va[3] = 32'hFFFF_FFFF; vb[3] = 32'hFFFF_FFFF;  ve[3] = 64'd1;
    va[4] = 32'h7FFF_FFFF; vb[4] = 32'h7FFF_FFFF;  ve[4] = 64'h3FFF_FFFF_0000_0001;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i]);
      wait_done(lat);
      checks++;
      if (lat !== 16 || R !== ve[i]) begin
        $display("FAIL vec%0d: A=%h B=%h R=%h lat=%0d want R=%h lat=16",
                 i, va[i], vb[i], R, lat, ve[i]);
        errors++;
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [63:0] held;
    held = R;
    start_op(32'd3, 32'd5);
    repeat (4) @(posedge clk);
    // Pulse valid with different operands while busy.
    @(negedge clk);
    A     = 32'd100;
    B     = 32'd100;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    checks++;
    if (R !== held || ready !== 1'b0) begin
      $display("FAIL busy_hold: R=%h ready=%b want R=%h ready=0", R, ready, held);
      errors++;
    end
    wait_done(lat);
    checks++;
    if (R !== 64'd15 || lat !== 11) begin
      $display("FAIL busy_result: R=%h lat=%0d want R=f lat=11", R, lat);
      errors++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1 || R !== 64'd15) begin
      $display("FAIL busy_no_restart: R=%h ready=%b want R=f ready=1", R, ready);
      errors++;
    end
    start_op(32'd100, 32'd100);
    wait_done(lat);
    checks++;
    if (R !== 64'h2710) begin
      $display("FAIL busy_next: R=%h want %h", R, 64'h2710);
      errors++;
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    start_op(32'd1234, 32'hFFFF_FFFF);
    repeat (7) @(posedge clk);
    @(negedge clk);
    #1;
    async_rst = 1'b1;
    #1;
    checks++;
    if (R !== 64'd0 || ready !== 1'b1) begin
      $display("FAIL midop_rst: R=%h ready=%b want R=0 ready=1", R, ready);
      errors++;
    end
    @(negedge clk);
    async_rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (R !== 64'd0 || ready !== 1'b1) begin
      $display("FAIL midop_no_partial: R=%h ready=%b want R=0 ready=1", R, ready);
      errors++;
    end
    start_op(32'd2, 32'hFFFF_FFFD);
    wait_done(lat);
    checks++;
    if (R !== 64'hFFFF_FFFF_FFFF_FFFA || lat !== 16) begin
      $display("FAIL midop_fresh: R=%h lat=%0d want R=fffffffffffffffa lat=16", R, lat);
      errors++;
    end
  endtask

  // valid held high: each new op starts on the edge after ready rises.
  task automatic test_back_to_back();
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    logic [63:0] exp_q [$];
    logic [63:0] want;
    int lat;
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = $urandom;
      exp_b[i] = $urandom;
      exp_a[i][31] = i[1];
      exp_b[i][31] = i[0];
      exp_q.push_back(64'(longint'($signed(exp_a[i])) * longint'($signed(exp_b[i]))));
    end
    @(negedge clk);
    A     = exp_a[0];
    B     = exp_b[0];
    valid = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      wait_done(lat);
      want = exp_q.pop_front();
      checks++;
      if (R !== want || lat !== 16) begin
        $display("FAIL b2b%0d: A=%h B=%h R=%h lat=%0d want R=%h lat=16",
                 i, exp_a[i], exp_b[i], R, lat, want);
        errors++;
      end
      if (i < 3) begin
        @(negedge clk);
        A = exp_a[i+1];
        B = exp_b[i+1];
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || R !== want) begin
          $display("FAIL b2b_restart%0d: ready=%b R=%h want ready=0 R=%h",
                   i, ready, R, want);
          errors++;
        end
      end
    end
    valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_positive();
    test_signs_extremes();
    test_busy_ignore();
    test_reset_midop();
    test_reset_async();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_multiplier32.md
Name: booth_multiplier32

Overview:
Sequential 32x32 signed two's-complement multiplier using radix-4 (modified) Booth recoding, one recoded digit per clock, 16 iterations per product. It sits as a multi-cycle arithmetic unit behind a simple valid/ready handshake. The 64-bit product is held on R until the next operation completes.

Parameters:
None (operand width fixed at 32, product width 64, iteration count 16).

Ports:
clk  input  1  rising-edge clock
async_rst  input  1  asynchronous active-high reset; takes effect immediately, independent of clk
valid  input  1  start request; sampled on rising clk edge
A  input  32  signed multiplicand, two's complement; sampled when a start is accepted
B  input  32  signed multiplier, two's complement; sampled when a start is accepted
R  output  64  signed product A*B (two's complement); registered
ready  output  1  1 = idle, R holds a complete result, new start accepted; 0 = busy

Behaviour:
- Reset (async_rst=1, asynchronous, active-high): R=0, ready=1, FSM=IDLE, internal accumulator/multiplier/counter cleared. Reset mid-operation aborts the computation; no partial result ever reaches R.
- FSM states: IDLE, CALC.
- IDLE: ready=1. On a rising edge with valid=1:
  - capture A (multiplicand M) and B (multiplier Q, with an appended 0 as bit -1)
  - clear accumulator and counter
  - go to CALC, drop ready to 0
- IDLE with valid=0: R and ready hold.
- CALC: one Booth step per rising edge, 16 steps total (counter 0..15).
  - Step i examines triplet {Q[2i+1], Q[2i], Q[2i-1]}:
    - 000 or 111 -> +0
    - 001 or 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101 or 110 -> -M
  - Partial products are sign-extended to at least 34 bits before adding.
  - The accumulator/multiplier pair is arithmetically shifted right by 2 each step. Any equivalent shifted-accumulator structure is acceptable as long as the result is bit-exact.
- Completion: on the edge performing step 15, write the full signed 64-bit product to R, set ready=1, return to IDLE.
- Latency: start accepted at edge N -> R valid and ready=1 after edge N+16. Result is present well within 20 cycles of the start.
- R changes only at completion (or reset). During CALC, R keeps the previous result.
- valid while busy (CALC) is ignored; no queuing, no restart.
- valid held high continuously: a new operation starts on the first IDLE edge after completion, i.e. the edge after ready rises.
- A/B may change freely after the start edge; operands are latched.
- Arithmetic is exact for all operand pairs, including -2^31 * -2^31 = +2^62. No overflow is possible in 64 bits.

Test Plan:
- Reset: assert async_rst between clock edges -> R=0 and ready=1 immediately, without waiting for an edge.
- Positive operands: A=3, B=5, valid for one edge -> ready low for 16 cycles, then R=0x000000000000000F, ready=1, R stable thereafter.
- Mixed signs:
  - A=-7, B=6 -> R=0xFFFFFFFFFFFFFFD6
  - A=0x7FFFFFFF, B=0x80000000 -> R=0xC000000080000000
- Both negative / extremes:
  - A=B=0x80000000 -> R=0x4000000000000000
  - A=B=0xFFFFFFFF -> R=1
- Busy protection: start A=3, B=5; pulse valid with A=100, B=100 mid-computation -> final R=15; only the next start after ready=1 yields 10000 (0x2710).
- Reset mid-operation: start A=1234, B=-1; assert async_rst at cycle 8 -> R=0, ready=1; a fresh start A=2, B=-3 gives R=0xFFFFFFFFFFFFFFFA.
- Random regression: 4 back-to-back ops covering (+,+), (+,-), (-,+), (-,-) random 32-bit operands, each checked against a 64-bit signed reference product once ready=1.
